// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor: FSM states,
// default parameter values and the lock-loss saturation helper.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_LOCK_STABLE_CYCLES = 4800;
  localparam int DEF_WINDOW_CYCLES      = 1024;
  localparam int DEF_EDGE_MIN           = 60;
  localparam int DEF_EDGE_MAX           = 73;
  localparam int DEF_CNT_W              = 16;

  localparam logic [7:0] LOSS_SAT = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == LOSS_SAT) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its environment.
interface pll_lock_supervisor_if #(
  parameter int CNT_W = 16
);
  logic             locked;
  logic             pll_toggle;
  logic             fault_clear;
  logic             sys_reset;
  logic             pll_ok;
  logic             freq_fault;
  logic             meas_valid;
  logic [CNT_W-1:0] measured_edges;
  logic [7:0]       lock_loss_count;

  modport master (
    output locked, pll_toggle, fault_clear,
    input  sys_reset, pll_ok, freq_fault, meas_valid, measured_edges, lock_loss_count
  );

  modport slave (
    input  locked, pll_toggle, fault_clear,
    output sys_reset, pll_ok, freq_fault, meas_valid, measured_edges, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor_cdc_sync.sv
// Multi-stage single-bit synchroniser for asynchronous inputs (STAGES >= 2).
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // shift chain; first stage may go metastable, later stages settle it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock, holds the PLL-domain reset until lock is stable,
// counts lock losses and checks PLL frequency via a divided toggle.
module pll_lock_supervisor
  import pll_mon_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int WINDOW_CYCLES      = DEF_WINDOW_CYCLES,
  parameter int EDGE_MIN           = DEF_EDGE_MIN,
  parameter int EDGE_MAX           = DEF_EDGE_MAX,
  parameter int CNT_W              = DEF_CNT_W
) (
  input logic                  clock_in,
  input logic                  reset,
  pll_lock_supervisor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONES   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] EDGE_MIN_C = CNT_W'(EDGE_MIN);
  localparam logic [CNT_W-1:0] EDGE_MAX_C = CNT_W'(EDGE_MAX);

  logic             lock_s;
  logic             tog_sync_s;
  logic             tog_hist_r;
  logic             edge_s;
  state_t           state_r;
  state_t           next_state_s;
  logic             loss_s;
  logic [CNT_W-1:0] stab_cnt_r;
  logic [CNT_W-1:0] win_cnt_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic [CNT_W-1:0] edge_total_s;
  logic             mon_active_s;
  logic             win_end_s;
  logic             eval_fail_s;
  logic             fault_nxt_s;

  logic             sys_reset_r;
  logic             pll_ok_r;
  logic             freq_fault_r;
  logic             meas_valid_r;
  logic [CNT_W-1:0] measured_r;
  logic [7:0]       loss_cnt_r;

  cdc_sync #(.STAGES(2)) u_lock_sync (
    .clk (clock_in),
    .rst (reset),
    .d   (bus.locked),
    .q   (lock_s)
  );

  cdc_sync #(.STAGES(2)) u_tog_sync (
    .clk (clock_in),
    .rst (reset),
    .d   (bus.pll_toggle),
    .q   (tog_sync_s)
  );

  assign edge_s = tog_sync_s ^ tog_hist_r;

  // lock qualification: a loss is only counted when leaving RUN
  always_comb begin
    next_state_s = state_r;
    loss_s       = 1'b0;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) next_state_s = STABILISE;
        else        next_state_s = WAIT_LOCK;
      end
      STABILISE: begin
        if (!lock_s)                      next_state_s = WAIT_LOCK;
        else if (stab_cnt_r == STAB_LAST) next_state_s = RUN;
        else                              next_state_s = STABILISE;
      end
      RUN: begin
        if (!lock_s) begin
          next_state_s = WAIT_LOCK;
          loss_s       = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      default: next_state_s = WAIT_LOCK;
    endcase
  end

  // monitor runs only while staying in STABILISE/RUN; leaving drops the window
  always_comb begin
    mon_active_s = (state_r != WAIT_LOCK) && lock_s;
    win_end_s    = mon_active_s && (win_cnt_r == WIN_LAST);
    if (edge_s && (edge_cnt_r != CNT_ONES)) edge_total_s = edge_cnt_r + CNT_ONE;
    else                                    edge_total_s = edge_cnt_r;
    eval_fail_s = win_end_s && ((edge_total_s < EDGE_MIN_C) || (edge_total_s > EDGE_MAX_C));
    if (eval_fail_s)          fault_nxt_s = 1'b1;
    else if (bus.fault_clear) fault_nxt_s = 1'b0;
    else                      fault_nxt_s = freq_fault_r;
  end

  // state, counters and registered outputs
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_r      <= WAIT_LOCK;
      tog_hist_r   <= 1'b0;
      stab_cnt_r   <= CNT_ZERO;
      win_cnt_r    <= CNT_ZERO;
      edge_cnt_r   <= CNT_ZERO;
      sys_reset_r  <= 1'b1;
      pll_ok_r     <= 1'b0;
      freq_fault_r <= 1'b0;
      meas_valid_r <= 1'b0;
      measured_r   <= CNT_ZERO;
      loss_cnt_r   <= 8'd0;
    end else begin
      state_r    <= next_state_s;
      tog_hist_r <= tog_sync_s;

      if ((state_r == STABILISE) && lock_s) stab_cnt_r <= stab_cnt_r + CNT_ONE;
      else                                  stab_cnt_r <= CNT_ZERO;

      if (mon_active_s && !win_end_s) begin
        win_cnt_r  <= win_cnt_r + CNT_ONE;
        edge_cnt_r <= edge_total_s;
      end else begin
        win_cnt_r  <= CNT_ZERO;
        edge_cnt_r <= CNT_ZERO;
      end

      meas_valid_r <= win_end_s;
      if (win_end_s) measured_r <= edge_total_s;

      freq_fault_r <= fault_nxt_s;
      sys_reset_r  <= (next_state_s != RUN);
      pll_ok_r     <= (next_state_s == RUN) && !fault_nxt_s;
      if (loss_s) loss_cnt_r <= sat_inc8(loss_cnt_r);
    end
  end

  assign bus.sys_reset       = sys_reset_r;
  assign bus.pll_ok          = pll_ok_r;
  assign bus.freq_fault      = freq_fault_r;
  assign bus.meas_valid      = meas_valid_r;
  assign bus.measured_edges  = measured_r;
  assign bus.lock_loss_count = loss_cnt_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench: directed scenarios plus random lock/frequency traffic,
// compared every cycle against a run-length based behavioural model.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int LSC  = 16;
  localparam int WIN  = 1024;
  localparam int EMIN = 60;
  localparam int EMAX = 73;
  localparam int CW   = 16;
  localparam int HALF_NOM  = 15360;   // 66.7 edges per window
  localparam int HALF_SLOW = 20480;   // 50 edges per window
  localparam int HALF_FAST = 12800;   // 80 edges per window

  logic clock_in = 1'b0;
  logic reset;

  pll_lock_supervisor_if #(.CNT_W(CW)) bus ();

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES (LSC),
    .WINDOW_CYCLES      (WIN),
    .EDGE_MIN           (EMIN),
    .EDGE_MAX           (EMAX),
    .CNT_W              (CW)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 clock_in = ~clock_in;

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;
  int tog_half = HALF_NOM;

  always @(posedge clock_in) ecount <= ecount + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Toggle source: phase accumulator stepped on negedges, so it never races posedge.
  initial begin
    int acc;
    bus.pll_toggle = 1'b0;
    acc = int'($urandom_range(0, HALF_NOM - 1));
    forever begin
      @(negedge clock_in);
      acc += 1000;
      if (acc >= tog_half) begin
        acc -= tog_half;
        bus.pll_toggle = ~bus.pll_toggle;
      end
    end
  end

  // Behavioural model: lock qualified after LSC+1 consecutive synchronised-high
  // samples; windows are counted in cycles since the monitor became active.
  bit [1:0] lk_q;
  bit [2:0] tg_q;
  int  m_run, m_acc, m_meas, m_loss, k_m;
  bit  m_sys_reset, m_pll_ok, m_fault, m_valid;
  bit  seen_m, ed_m, was_run_m, fail_m;

  always @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lk_q = 2'b00; tg_q = 3'b000;
      m_run = 0; m_acc = 0; m_meas = 0; m_loss = 0;
      m_sys_reset = 1'b1; m_pll_ok = 1'b0; m_fault = 1'b0; m_valid = 1'b0;
    end else begin
      seen_m = lk_q[1];
      ed_m   = tg_q[1] ^ tg_q[2];
      lk_q   = {lk_q[0], bus.locked};
      tg_q   = {tg_q[1:0], bus.pll_toggle};
      was_run_m = (m_run >= LSC + 1);
      m_run  = seen_m ? m_run + 1 : 0;
      m_sys_reset = !(m_run >= LSC + 1);
      if (was_run_m && !seen_m && m_loss < 255) m_loss++;
      m_valid = 1'b0;
      fail_m  = 1'b0;
      if (m_run >= 2) begin
        k_m = m_run - 2;
        if (k_m % WIN == 0) m_acc = 0;
        m_acc += int'(ed_m);
        if (k_m % WIN == WIN - 1) begin
          m_valid = 1'b1;
          m_meas  = m_acc;
          fail_m  = (m_acc < EMIN) || (m_acc > EMAX);
        end
      end
      if (fail_m) m_fault = 1'b1;
      else if (bus.fault_clear) m_fault = 1'b0;
      m_pll_ok = !m_sys_reset && !m_fault;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock_in);
      check("cyc_sys_reset", bus.sys_reset, m_sys_reset);
      check("cyc_pll_ok", bus.pll_ok, m_pll_ok);
      check("cyc_freq_fault", bus.freq_fault, m_fault);
      check("cyc_meas_valid", bus.meas_valid, m_valid);
      check("cyc_measured", bus.measured_edges, m_meas);
      check("cyc_loss", bus.lock_loss_count, m_loss);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic measure_release(input string name);
    int e0, n;
    bit seen;
    e0 = ecount;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock_in);
      if (bus.sys_reset == 1'b0) seen = 1'b1;
    end
    n = seen ? ecount - e0 : -1;
    check(name, n, LSC + 3);
  endtask

  task automatic wait_model_meas(input string name, input bit need_fail);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3 * WIN + 20 && !got; i++) begin
      @(negedge clock_in);
      if (m_valid && (!need_fail || m_meas < EMIN)) got = 1'b1;
    end
    check(name, got, 1);
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    bus.locked = 1'b0;
    bus.fault_clear = 1'b0;
    tick(3);
    check("rst_sys_reset", bus.sys_reset, 1);
    check("rst_pll_ok", bus.pll_ok, 0);
    check("rst_meas_valid", bus.meas_valid, 0);

    // Scenario 1: lock rises with reset release and is held
    reset = 1'b0;
    bus.locked = 1'b1;
    measure_release("t1_release_edge");
    check("t1_pll_ok", bus.pll_ok, 1);
    got = 1'b0;
    for (int i = 0; i < WIN + 40 && !got; i++) begin
      @(negedge clock_in);
      if (bus.meas_valid) got = 1'b1;
    end
    check("t1_meas_seen", got, 1);
    check("t1_meas_nominal", int'(bus.measured_edges inside {[66:67]}), 1);
    check("t1_freq_fault", bus.freq_fault, 0);

    // Scenario 6: asynchronous reset between edges while in RUN
    tick(5);
    #3 reset = 1'b1;
    #1;
    check("t6_sys_reset_now", bus.sys_reset, 1);
    check("t6_pll_ok_now", bus.pll_ok, 0);
    check("t6_measured_now", bus.measured_edges, 0);
    check("t6_loss_now", bus.lock_loss_count, 0);
    tick(2);
    reset = 1'b0;
    measure_release("t6_requalify_edge");

    // Scenario 2: short lock glitch during qualification is not a loss
    reset = 1'b1;
    bus.locked = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    bus.locked = 1'b1;
    tick(10);
    bus.locked = 1'b0;
    tick(1);
    bus.locked = 1'b1;
    measure_release("t2_release_edge");
    check("t2_loss_zero", bus.lock_loss_count, 0);

    // Scenario 4: slow toggle trips freq_fault without touching sys_reset
    tog_half = HALF_SLOW;
    wait_model_meas("t4_slow_meas_seen", 1'b1);
    check("t4_meas_slow", int'(bus.measured_edges inside {[49:51]}), 1);
    check("t4_freq_fault", bus.freq_fault, 1);
    check("t4_pll_ok", bus.pll_ok, 0);
    check("t4_sys_reset", bus.sys_reset, 0);
    tog_half = HALF_NOM;
    bus.fault_clear = 1'b1;
    tick(1);
    bus.fault_clear = 1'b0;
    check("t4_clear_fault", bus.freq_fault, 0);
    check("t4_clear_pll_ok", bus.pll_ok, 1);

    // Scenario 5: fault_clear coinciding with a failing evaluation
    tog_half = HALF_SLOW;
    wait_model_meas("t5_first_meas", 1'b0);
    bus.fault_clear = 1'b1;
    tick(1);
    bus.fault_clear = 1'b0;
    check("t5_pre_clear", bus.freq_fault, 0);
    got = 1'b0;
    for (int i = 0; i < WIN + 20 && !got; i++) begin
      @(negedge clock_in);
      if (m_run >= 1 && ((m_run - 1) % WIN) == WIN - 1) got = 1'b1;
    end
    check("t5_found_window_end", got, 1);
    bus.fault_clear = 1'b1;
    tick(1);
    bus.fault_clear = 1'b0;
    check("t5_meas_valid", bus.meas_valid, 1);
    check("t5_fault_wins", bus.freq_fault, 1);
    check("t5_pll_ok", bus.pll_ok, 0);
    tog_half = HALF_NOM;

    // Scenario 3: lock loss in RUN, then saturation of the loss counter
    bus.locked = 1'b0;
    tick(1);
    check("t3_edge1_sys_reset", bus.sys_reset, 0);
    tick(1);
    check("t3_edge2_sys_reset", bus.sys_reset, 0);
    tick(1);
    check("t3_edge3_sys_reset", bus.sys_reset, 1);
    check("t3_loss_one", bus.lock_loss_count, 1);
    for (int i = 0; i < 300; i++) begin
      bus.locked = 1'b1;
      tick(int'($urandom_range(20, 30)));
      bus.locked = 1'b0;
      tick(int'($urandom_range(2, 4)));
    end
    check("t3_loss_sat", bus.lock_loss_count, 255);

    // Random traffic: lock drops, frequency changes and fault clears
    bus.locked = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock_in);
      bus.fault_clear = ($urandom_range(0, 49) == 0);
      if (bus.locked && $urandom_range(0, 599) == 0) bus.locked = 1'b0;
      else if (!bus.locked && $urandom_range(0, 7) == 0) bus.locked = 1'b1;
      if (c % 700 == 0) begin
        case ($urandom_range(0, 3))
          0: tog_half = HALF_SLOW;
          1: tog_half = HALF_FAST;
          default: tog_half = HALF_NOM;
        endcase
      end
    end
    bus.fault_clear = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
